// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready on both sides; shifts run serially
// one bit per cycle unless ALU_FAST_SHIFT_EN is defined (single-cycle barrel shifter).
module alu_exec_unit #(
  parameter logic [31:0] XORID_KEY = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal,
  output logic        busy
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;
  localparam logic [3:0] OP_XORID = 4'b1111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_illegal;

  logic        w_accept;
  logic [4:0]  w_shamt;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [31:0] w_result;
  logic        w_illegal;

  assign w_accept = in_valid & in_ready;
  assign w_shamt  = src_b[4:0];

`ifdef ALU_FAST_SHIFT_EN
  assign w_sll = src_a << w_shamt;
  assign w_srl = src_a >> w_shamt;
  assign w_sra = $unsigned($signed(src_a) >>> w_shamt);
`else
  // Only reached with shamt==0 here; nonzero shifts go through the serial path.
  assign w_sll = src_a;
  assign w_srl = src_a;
  assign w_sra = src_a;

  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [1:0]  r_shift_op;
  logic [31:0] w_acc_next;
  logic        w_start_serial;

  assign w_start_serial = (alu_control inside {OP_SLL, OP_SRL, OP_SRA}) && (w_shamt != 5'd0);

  // Shift kind is carried in the low two opcode bits: 01 SLL, 10 SRL, 11 SRA.
  always_comb begin
    w_acc_next = r_acc;
    case (r_shift_op)
      2'b01:   w_acc_next = {r_acc[30:0], 1'b0};
      2'b10:   w_acc_next = {1'b0, r_acc[31:1]};
      default: w_acc_next = {r_acc[31], r_acc[31:1]};
    endcase
  end
`endif

  always_comb begin
    w_result  = 32'd0;
    w_illegal = 1'b0;
    case (alu_control)
      OP_ADD:   w_result = src_a + src_b;
      OP_SUB:   w_result = src_a - src_b;
      OP_AND:   w_result = src_a & src_b;
      OP_OR:    w_result = src_a | src_b;
      OP_XOR:   w_result = src_a ^ src_b;
      OP_SLL:   w_result = w_sll;
      OP_SRL:   w_result = w_srl;
      OP_SRA:   w_result = w_sra;
      OP_SLT:   w_result = {31'd0, $signed(src_a) < $signed(src_b)};
      OP_SLTU:  w_result = {31'd0, src_a < src_b};
      OP_PASSB: w_result = src_b;
      OP_XORID: w_result = src_a ^ src_b ^ XORID_KEY;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_result   <= 32'd0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      r_acc      <= 32'd0;
      r_cnt      <= 5'd0;
      r_shift_op <= 2'b00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if (w_start_serial) begin
              r_acc      <= src_a;
              r_cnt      <= w_shamt;
              r_shift_op <= alu_control[1:0];
              r_state    <= S_SHIFT;
            end else begin
              r_result   <= w_result;
              r_zero     <= (w_result == 32'd0);
              r_illegal  <= w_illegal;
              r_state    <= S_DONE;
            end
`else
            r_result  <= w_result;
            r_zero    <= (w_result == 32'd0);
            r_illegal <= w_illegal;
            r_state   <= S_DONE;
`endif
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result  <= w_acc_next;
            r_zero    <= (w_acc_next == 32'd0);
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~reset;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
